// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
//   DATA_WIDTH  : width of a stored word
//   DEPTH       : number of storage entries (power of two)
//   ADDR_WIDTH  : pointer width, log2(DEPTH)
//   COUNT_WIDTH : occupancy counter width; one extra bit so DEPTH is representable
package fifo_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int DEPTH       = 8;
  localparam int ADDR_WIDTH  = $clog2(DEPTH);
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0]  data_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  localparam count_t FULL_COUNT = count_t'(DEPTH);
endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a FIFO user and the FIFO.
//   en      : block enable; 0 freezes all FIFO state
//   rd, wr  : read / write requests
//   dataIn  : write data
//   dataOut : registered read data
//   empty   : occupancy == 0
//   full    : occupancy == DEPTH
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_if;
  import fifo_pkg::*;

  logic  en;
  logic  rd;
  logic  wr;
  data_t dataIn;
  data_t dataOut;
  logic  empty;
  logic  full;

  modport master (
    output en, rd, wr, dataIn,
    input  dataOut, empty, full
  );

  modport slave (
    input  en, rd, wr, dataIn,
    output dataOut, empty, full
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage array, no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read data (registered by the caller)
module fifo_mem
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  addr_t raddr,
  output data_t rdata
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and empty/full flags.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; clears pointers, count and dataOut
//   bus   : sync_fifo_if.slave (en, rd, wr, dataIn, dataOut, empty, full)
// Flags decode the registered count, so no input reaches an output combinationally.
module sync_fifo
  import fifo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  sync_fifo_if.slave  bus
);

  addr_t  wptr_q, wptr_d;
  addr_t  rptr_q, rptr_d;
  count_t count_q, count_d;
  data_t  dout_q, dout_d;

  logic   empty_w;
  logic   full_w;
  logic   rd_acc;
  logic   wr_acc;
  data_t  rdata;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_COUNT);

  // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
  assign rd_acc = bus.en & bus.rd & ~empty_w;
  assign wr_acc = bus.en & bus.wr & (~full_w | rd_acc);

  fifo_mem u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (bus.dataIn),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;

    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = rdata;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.dataOut = dout_q;
  assign bus.empty   = empty_w;
  assign bus.full    = full_w;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk;
  logic reset;

  sync_fifo_if bus ();

  sync_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [7:0] model  [$];   // words the FIFO should currently hold
  logic [7:0] exp_q  [$];   // words expected on dataOut, in order
  logic [7:0] exp_dout;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_dout"},  bus.dataOut, exp_dout);
    check({tag, "_empty"}, {7'd0, bus.empty}, {7'd0, model.size() == 0});
    check({tag, "_full"},  {7'd0, bus.full},  {7'd0, model.size() == DEPTH});
  endtask

  // One clock of stimulus; the reference model decides what the FIFO must accept.
  task automatic step(input string tag, input logic e, input logic w,
                      input logic [7:0] d, input logic r);
    logic rd_ok, wr_ok;
    @(negedge clk);
    bus.en = e; bus.wr = w; bus.dataIn = d; bus.rd = r;
    rd_ok = e && r && (model.size() != 0);
    wr_ok = e && w && ((model.size() != DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(model.pop_front());
    if (wr_ok) model.push_back(d);
    @(posedge clk);
    #1;
    if (rd_ok) exp_dout = exp_q.pop_front();
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    bus.en = 1'b1; bus.wr = 1'b0; bus.rd = 1'b0;
    #2 reset = 1'b0;
    #1;
    model.delete();
    exp_q.delete();
    exp_dout = '0;
    check({tag, "_dout"},  bus.dataOut, 8'h00);
    check({tag, "_empty"}, {7'd0, bus.empty}, 8'h01);
    check({tag, "_full"},  {7'd0, bus.full},  8'h00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.en = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.dataIn = '0;
    exp_dout = '0;
    #3;
    check("por_dout",  bus.dataOut, 8'h00);
    check("por_empty", {7'd0, bus.empty}, 8'h01);
    check("por_full",  {7'd0, bus.full},  8'h00);
    @(negedge clk);
    reset = 1'b1;

    // 1: asynchronous reset with data held and dataOut non-zero
    step("t1_w0", 1, 1, 8'h33, 0);
    step("t1_w1", 1, 1, 8'h44, 0);
    step("t1_r0", 1, 0, 8'h00, 1);
    async_reset("t1_rst");

    // 2: fill and drain
    step("t2_w0", 1, 1, 8'h03, 0);
    step("t2_w1", 1, 1, 8'h05, 0);
    step("t2_w2", 1, 1, 8'h0B, 0);
    step("t2_w3", 1, 1, 8'h02, 0);
    for (int i = 0; i < 4; i++) step("t2_rd", 1, 0, 8'h00, 1);
    step("t2_hold", 1, 0, 8'h00, 0);
    check("t2_last", bus.dataOut, 8'h02);

    // 3: full and overflow
    for (int i = 0; i < 8; i++) step("t3_fill", 1, 1, 8'h10 + 8'(i), 0);
    step("t3_ovf", 1, 1, 8'hFF, 0);
    for (int i = 0; i < 8; i++) step("t3_drain", 1, 0, 8'h00, 1);
    check("t3_last", bus.dataOut, 8'h17);

    // 4: streaming with wrap, then simultaneous rd/wr at full and at empty
    step("t4_pre0", 1, 1, 8'h20, 0);
    step("t4_pre1", 1, 1, 8'h21, 0);
    for (int i = 0; i < 20; i++) step("t4_stream", 1, 1, 8'h22 + 8'(i), 1);
    step("t4_d0", 1, 0, 8'h00, 1);
    step("t4_d1", 1, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) step("t4_fill", 1, 1, 8'h40 + 8'(i), 0);
    step("t4_rwfull", 1, 1, 8'h48, 1);
    for (int i = 0; i < 8; i++) step("t4_drain", 1, 0, 8'h00, 1);
    step("t4_rwempty", 1, 1, 8'h5A, 1);
    step("t4_d2", 1, 0, 8'h00, 1);

    // 5: enable hold and underflow
    step("t5_w0", 1, 1, 8'h61, 0);
    step("t5_w1", 1, 1, 8'h62, 0);
    for (int i = 0; i < 3; i++) step("t5_en0", 0, 1, 8'hAA, 1);
    step("t5_r0", 1, 0, 8'h00, 1);
    step("t5_r1", 1, 0, 8'h00, 1);
    step("t5_uf0", 1, 0, 8'h00, 1);
    step("t5_uf1", 1, 0, 8'h00, 1);

    // 6: reset mid-operation, then no stale data
    step("t6_w0", 1, 1, 8'h71, 0);
    step("t6_w1", 1, 1, 8'h72, 0);
    step("t6_w2", 1, 1, 8'h73, 0);
    async_reset("t6_rst");
    step("t6_w3", 1, 1, 8'h05, 0);
    step("t6_w4", 1, 1, 8'h0B, 0);
    step("t6_r0", 1, 0, 8'h00, 1);
    step("t6_r1", 1, 0, 8'h00, 1);
    step("t6_r2", 1, 0, 8'h00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
